// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: round-robin burst arbiter sharing one DDR port between NUM_REQ requesters
module ddr_burst_arbiter #(
  parameter int         NUM_REQ  = 3,
  parameter logic [3:0] DDR_BASE = 4'b0011
) (
  input  logic                  clkddr,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*29-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_burstcnt,
  input  logic [NUM_REQ*64-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_wbeat,
  output logic [NUM_REQ-1:0]    req_rvalid,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [63:0]           rdata,
  input  logic                  ddr_busy,
  input  logic [63:0]           ddr_rdata,
  input  logic                  ddr_rdata_ready,
  output logic                  ddr_acquire,
  output logic                  ddr_read,
  output logic                  ddr_write,
  output logic [28:0]           ddr_addr,
  output logic [7:0]            ddr_burstcnt,
  output logic [63:0]           ddr_wdata,
  output logic [7:0]            ddr_byteenable
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WDATA = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]         state;
  logic [IW-1:0]      sel, rr, pick;
  logic [NUM_REQ-1:0] sel_oh, pick_oh;
  logic               found, take, wr, unused_addr;
  logic [7:0]         cnt, bc;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % NUM_REQ);
  endfunction
  // scan downwards so the nearest index after the rr pointer wins
  always_comb begin
    pick = rr;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[nxt(rr, k)]) begin
        pick = nxt(rr, k);
        found = 1'b1;
      end
  end
  assign bc             = req_burstcnt[pick*8 +: 8];
  assign take           = state == IDLE && found && !reset;
  assign pick_oh        = NUM_REQ'(1) << pick;
  assign sel_oh         = NUM_REQ'(1) << sel;
  assign req_grant      = take ? pick_oh : '0;
  assign req_done       = state == DONE ? sel_oh : (take && bc == 8'd0 ? pick_oh : '0);
  assign req_wbeat      = state == WDATA && !ddr_busy ? sel_oh : '0;
  assign ddr_acquire    = state == ISSUE || state == RDATA || state == WDATA;
  assign ddr_read       = state == ISSUE && !wr;
  assign ddr_write      = state == WDATA;
  assign ddr_wdata      = ddr_write ? req_wdata[sel*64 +: 64] : '0;
  assign ddr_byteenable = 8'hff;
  assign unused_addr    = ^req_addr;
  always_ff @(posedge clkddr)
    if (reset) begin
      state        <= IDLE;
      rr           <= IW'(NUM_REQ - 1);
      sel          <= '0;
      wr           <= 1'b0;
      cnt          <= '0;
      ddr_addr     <= '0;
      ddr_burstcnt <= '0;
      rdata        <= '0;
      req_rvalid   <= '0;
    end else begin
      req_rvalid <= '0;
      case (state)
        IDLE: if (found) begin
          sel          <= pick;
          rr           <= pick;
          wr           <= req_write[pick];
          ddr_addr     <= {DDR_BASE, req_addr[pick*29+3 +: 25]};
          ddr_burstcnt <= bc;
          cnt          <= bc;
          state        <= bc == 8'd0 ? IDLE : ISSUE;
        end
        ISSUE: state <= wr ? WDATA : (ddr_busy ? ISSUE : RDATA);
        RDATA: if (ddr_rdata_ready) begin
          rdata      <= ddr_rdata;
          req_rvalid <= sel_oh;
          cnt        <= cnt - 8'd1;
          state      <= cnt == 8'd1 ? DONE : RDATA;
        end
        WDATA: if (!ddr_busy) begin
          cnt   <= cnt - 8'd1;
          state <= cnt == 8'd1 ? DONE : WDATA;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: table-driven bursts against a DDR model with a read-data scoreboard
module tb_ddr_burst_arbiter;
  localparam int N = 3;
  typedef struct {
    int          idx;
    bit          w;
    logic [28:0] addr;
    logic [7:0]  n;
    int          busy;
    logic [28:0] exp_addr;
  } vec_t;
  logic          clkddr = 0, reset = 1;
  logic [N-1:0]  req_valid = 0, req_write = 0;
  logic [N*29-1:0] req_addr = 0;
  logic [N*8-1:0]  req_burstcnt = 0;
  logic [N*64-1:0] req_wdata = 0;
  logic [N-1:0]  req_grant, req_wbeat, req_rvalid, req_done;
  logic [63:0]   rdata, ddr_rdata = 0, ddr_wdata;
  logic          ddr_busy = 0, ddr_rdata_ready = 0;
  logic          ddr_acquire, ddr_read, ddr_write;
  logic [28:0]   ddr_addr;
  logic [7:0]    ddr_burstcnt, ddr_byteenable;
  ddr_burst_arbiter #(.NUM_REQ(N)) dut (
    .clkddr(clkddr), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_burstcnt(req_burstcnt), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_wbeat(req_wbeat), .req_rvalid(req_rvalid), .req_done(req_done),
    .rdata(rdata), .ddr_busy(ddr_busy), .ddr_rdata(ddr_rdata), .ddr_rdata_ready(ddr_rdata_ready),
    .ddr_acquire(ddr_acquire), .ddr_read(ddr_read), .ddr_write(ddr_write), .ddr_addr(ddr_addr),
    .ddr_burstcnt(ddr_burstcnt), .ddr_wdata(ddr_wdata), .ddr_byteenable(ddr_byteenable)
  );
  always #5 clkddr = ~clkddr;
  int n_chk = 0, n_fail = 0;
  logic [63:0] q[$];
  int cyc = 0, cur_i = 0, busy_left = 0, pend = 0, wb = 0, nbeats = 0, ndone = 0, ngrant = 0;
  int grant_cyc = 0, done_cyc = 0, first_rd = -1, rst_g = -1;
  bit wtog = 0, drop = 0, saw_cmd = 0, auto_clr = 1, rst_fired = 0;
  logic [7:0]   cur_n = 0;
  logic [28:0]  exp_addr = 0;
  logic [N-1:0] clr_mask = 0, gnow = 0;
  vec_t vt[8];
  function automatic logic [63:0] wd(input int i, input int b);
    return {8'(i), 24'hc0ffee, 32'(b) * 32'h9e3779b1};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // entered at a negedge: drive the DDR model, sample outputs, return at the next negedge
  task automatic tick();
    cyc++;
    for (int i = 0; i < N; i++)
      if (clr_mask[i]) begin
        req_valid[i] = 1'b0;
        req_addr[i*29 +: 29] = 29'($urandom);
        req_burstcnt[i*8 +: 8] = 8'($urandom);
      end
    clr_mask = '0;
    req_wdata[cur_i*64 +: 64] = wd(cur_i, wb);
    ddr_busy = wtog ? cyc[0] : (busy_left > 0);
    ddr_rdata = {$urandom, $urandom};
    ddr_rdata_ready = 1'b0;
    if (pend > 0) begin
      if (cyc % 4 != 3) begin
        ddr_rdata_ready = 1'b1;
        if (!drop) q.push_back(ddr_rdata);
        pend--;
      end
    end else ddr_rdata_ready = cyc[0];
    #1;
    gnow = req_grant;
    if (req_grant != 0) begin
      ngrant++;
      grant_cyc = cyc;
      if (auto_clr) clr_mask |= req_grant;
    end
    if (ddr_read || ddr_write) saw_cmd = 1;
    if (ddr_read && first_rd < 0) first_rd = cyc;
    if (ddr_read && ddr_busy && busy_left > 0) busy_left--;
    if (ddr_read && !ddr_busy) begin
      chk("rd_addr", 64'(ddr_addr), 64'(exp_addr));
      chk("rd_burstcnt", 64'(ddr_burstcnt), 64'(cur_n));
      pend = cur_n;
    end
    if (ddr_write) begin
      chk("wr_addr_stable", 64'(ddr_addr), 64'(exp_addr));
      chk("wr_burstcnt", 64'(ddr_burstcnt), 64'(cur_n));
    end
    if (ddr_write || req_wbeat != 0)
      chk("wbeat", 64'(req_wbeat), (ddr_write && !ddr_busy) ? 64'(N'(1) << cur_i) : 64'd0);
    if (ddr_write && !ddr_busy) begin
      chk("wdata", ddr_wdata, wd(cur_i, wb));
      wb++;
    end
    if (req_rvalid != 0) begin
      chk("rvalid_idx", 64'(req_rvalid), 64'(N'(1) << cur_i));
      chk("rvalid_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("rdata", rdata, q.pop_front());
      nbeats++;
    end
    if (req_done != 0) begin
      chk("done_idx", 64'(req_done), 64'(N'(1) << cur_i));
      ndone++;
      done_cyc = cyc;
    end
    if (rst_g >= 0 && !drop && nbeats == rst_g) begin
      reset = 1'b1;
      drop = 1;
      rst_fired = 1;
      q.delete();
    end
    @(negedge clkddr);
  endtask
  task automatic run_burst(input vec_t v, input int rst_at);
    cur_i = v.idx; cur_n = v.n; exp_addr = v.exp_addr;
    wb = 0; nbeats = 0; ndone = 0; ngrant = 0; pend = 0; first_rd = -1;
    saw_cmd = 0; drop = 0; rst_fired = 0; rst_g = rst_at; auto_clr = 1;
    busy_left = v.w ? 0 : v.busy;
    wtog = v.w && v.busy > 0;
    req_valid[v.idx] = 1'b1;
    req_write[v.idx] = v.w;
    req_addr[v.idx*29 +: 29] = v.addr;
    req_burstcnt[v.idx*8 +: 8] = v.n;
    for (int c = 0; c < 800 && ndone == 0 && !rst_fired; c++) begin
      tick();
      if (gnow != 0) chk("grant_idx", 64'(gnow), 64'(N'(1) << v.idx));
    end
    if (rst_at >= 0) begin
      reset = 1'b0;
      tick();
      chk("rst_ctrl_zero", 64'({ddr_acquire, ddr_read, ddr_write, req_grant, req_wbeat,
                                req_rvalid, req_done, ddr_burstcnt}), 64'd0);
      chk("rst_rdata_zero", rdata, 64'd0);
      chk("rst_addr_zero", 64'(ddr_addr), 64'd0);
      for (int c = 0; c < 40 && pend > 0; c++) tick();
      repeat (3) tick();
      chk("rst_beats", 64'(nbeats), 64'(rst_at));
      chk("rst_no_done", 64'(ndone), 64'd0);
      rst_g = -1;
    end else begin
      chk("done_count", 64'(ndone), 64'd1);
      chk("grant_count", 64'(ngrant), 64'd1);
      if (v.n == 0) begin
        repeat (3) tick();
        chk("null_same_cycle", 64'(done_cyc), 64'(grant_cyc));
        chk("null_no_cmd", 64'(saw_cmd), 64'd0);
      end else if (v.w) chk("wr_beats", 64'(wb), 64'(v.n));
      else begin
        chk("rd_beats", 64'(nbeats), 64'(v.n));
        chk("issue_latency", 64'(first_rd - grant_cyc), 64'd1);
      end
      chk("queue_empty", 64'(q.size()), 64'd0);
    end
  endtask
  initial begin
    int k;
    logic [28:0] a;
    vt[0] = '{0, 0, 29'h0001_0008, 8'd4,   2, 29'h0600_2001};
    vt[1] = '{1, 1, 29'h0ABC_DEF0, 8'd3,   1, 29'h0757_9BDE};
    vt[2] = '{2, 0, 29'h1000_0040, 8'd0,   0, 29'h0600_0008};
    vt[3] = '{2, 0, 29'h0FFF_FFFF, 8'd5,   0, 29'h07FF_FFFF};
    vt[4] = '{0, 1, 29'h0000_0100, 8'd1,   0, 29'h0600_0020};
    vt[5] = '{1, 0, 29'h0123_4568, 8'd8,   3, 29'h0624_68AD};
    vt[6] = '{2, 1, 29'h0000_0000, 8'd0,   0, 29'h0600_0000};
    vt[7] = '{0, 0, 29'h0000_0008, 8'd255, 0, 29'h0600_0001};
    @(negedge clkddr);
    tick();
    tick();
    chk("reset_ctrl", 64'({ddr_acquire, ddr_read, ddr_write, req_grant, req_wbeat,
                           req_rvalid, req_done, ddr_burstcnt}), 64'd0);
    chk("reset_addr", 64'(ddr_addr), 64'd0);
    chk("reset_wdata", ddr_wdata, 64'd0);
    chk("byteenable", 64'(ddr_byteenable), 64'hff);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_burst(vt[i], -1);
    // round robin: all requesters held valid, single-beat reads
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cur_n = 1; busy_left = 0; wtog = 0; auto_clr = 0; drop = 0; pend = 0;
    ngrant = 0; ndone = 0; nbeats = 0; wb = 0;
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'b0;
      req_burstcnt[i*8 +: 8] = 8'd1;
      req_addr[i*29 +: 29] = 29'(32'h400 * (i + 1));
    end
    req_valid = '1;
    for (int c = 0; c < 200 && ndone < 6; c++) begin
      tick();
      if (gnow != 0) begin
        k = ngrant - 1;
        chk("rr_order", 64'(gnow), 64'(N'(1) << (k % N)));
        chk("rr_done_between", 64'(ndone), 64'(k));
        cur_i = k % N;
        a = req_addr[cur_i*29 +: 29];
        exp_addr = {4'b0011, a[27:3]};
        if (ngrant == 6) req_valid = '0;
      end
    end
    chk("rr_done_count", 64'(ndone), 64'd6);
    chk("rr_beats", 64'(nbeats), 64'd6);
    chk("rr_grants", 64'(ngrant), 64'd6);
    run_burst('{0, 0, 29'h0000_2000, 8'd8, 1, 29'h0600_0400}, 2);
    run_burst('{0, 0, 29'h0000_3008, 8'd2, 0, 29'h0600_0601}, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
